// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: SRAM-like instruction port, redirect input and the decode handoff.
// The master modport belongs to the fetch unit; the slave modport is the memory/decode side.
// Backpressure reaches the fetch unit through inst_addr_ok/inst_data_ok and id_ready.
interface inst_fetch_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        output inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// PC generator + single-outstanding instruction fetch, delivering {pc, inst} to decode.
// Latency: accept in cycle N, data_ok no earlier than N+1, id_valid no earlier than N+2.
// Backpressure: one word is held stable in HOLD until id_ready; no new request meanwhile.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               resetn,
    inst_fetch_unit_if.master  fif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } id_pkt_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        id_valid_q, id_valid_d;
    id_pkt_t     id_q, id_d;
    logic        misaligned;

    assign misaligned    = pc_q[1:0] != 2'b00;
    assign fif.inst_req  = (state_q == REQ) && !misaligned;
    assign fif.inst_addr = pc_q;
    assign fif.id_valid  = id_valid_q;
    assign fif.id_pc     = id_q.pc;
    assign fif.id_inst   = id_q.inst;
    assign fif.id_adel   = id_q.adel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_q       <= id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        id_valid_d = id_valid_q;
        id_d       = id_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (fif.redirect_valid) pc_d = fif.redirect_pc;
            end
            REQ: begin
                if (fif.redirect_valid) begin
                    pc_d = fif.redirect_pc;
                    // The request accepted this cycle fetches the old pc; mark its response stale.
                    if (!misaligned && fif.inst_addr_ok) begin
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end else if (misaligned) begin
                    state_d    = HOLD;
                    id_valid_d = 1'b1;
                    id_d       = '{pc: pc_q, inst: 32'h0, adel: 1'b1};
                end else if (fif.inst_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fif.redirect_valid) begin
                    pc_d = fif.redirect_pc;
                    if (fif.inst_data_ok) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (fif.inst_data_ok) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        id_valid_d = 1'b1;
                        id_d       = '{pc: pc_q, inst: fif.inst_rdata, adel: 1'b0};
                        pc_d       = pc_q + 32'd4;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // A redirect drops an unaccepted word; an accepted one has already left.
                if (fif.redirect_valid) begin
                    pc_d       = fif.redirect_pc;
                    id_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (id_valid_q && fif.id_ready) begin
                    id_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
